pipeline_run_ctrl: RTL and testbench
====================================

# pipeline_run_ctrl

Execution controller for the MIPS pipeline. It sequences the datapath from IF through write-back in either continuous-run or single-step mode. It stops fetching once a HALT instruction is fetched, drains the pipeline until HALT retires, then reports done. It also snoops the write-back stage's register-write outputs and counts enabled cycles and committed register writes, both for the debug unit.

## Interface
Parameters:
- LEN, 32, width of cycle and write-back counters
- NB_ADDRESS_REGISTROS, 5, register address width
- DRAIN_CYCLES, 4, enabled cycles from HALT fetch until HALT leaves write-back

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_start_run  in  1  start continuous execution; sampled in IDLE only
- i_start_step  in  1  enter single-step mode; sampled in IDLE only
- i_step  in  1  advance one cycle; sampled in STEP_WAIT only
- i_halt_fetched  in  1  IF holds a HALT opcode; valid only while o_pipe_enable=1 and o_fetch_enable=1
- i_RegWrite  in  1  write-back RegWrite output
- i_write_reg  in  NB_ADDRESS_REGISTROS  write-back destination register
- o_pipe_enable  out  1  global pipeline/latch enable
- o_fetch_enable  out  1  PC update / IF enable
- o_cycle_count  out  LEN  count of enabled cycles
- o_wb_count  out  LEN  count of committed register writes
- o_done  out  1  program finished
- o_state  out  3  current FSM state, for debug readout

## Operation
- Moore FSM. All outputs decode from registered state or counters; there are no combinational input-to-output paths.
- State encodings: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.
- IDLE
  - pipe_enable=0, fetch_enable=0.
  - i_start_run → RUN; else i_start_step → STEP_WAIT. If both are high, run wins.
  - Leaving IDLE clears both counters and halt_seen.
- RUN
  - pipe_enable=1, fetch_enable=1.
  - i_halt_fetched → DRAIN, and drain_cnt loads DRAIN_CYCLES.
  - i_step is ignored.
- DRAIN
  - pipe_enable=1, fetch_enable=0.
  - drain_cnt decrements each cycle. When drain_cnt==1 → DONE.
  - Occupies exactly DRAIN_CYCLES cycles.
- STEP_WAIT
  - pipe_enable=0.
  - i_step → STEP_EXEC.
- STEP_EXEC
  - pipe_enable=1 for exactly one cycle; fetch_enable = !halt_seen.
  - If !halt_seen and i_halt_fetched: set halt_seen, load drain_cnt=DRAIN_CYCLES, go to STEP_WAIT.
  - Else if halt_seen and drain_cnt==1 → DONE.
  - Else if halt_seen: decrement drain_cnt, go to STEP_WAIT.
  - Else → STEP_WAIT.
- DONE
  - o_done=1, pipe_enable=0, fetch_enable=0. Counters hold for readout.
  - All start/step inputs are ignored. Exit is by i_reset only.
- o_cycle_count: +1 in every cycle with o_pipe_enable=1. Saturates at all-ones.
- o_wb_count: +1 when o_pipe_enable && i_RegWrite && i_write_reg!=0. Saturates at all-ones. Writes to $0 are never counted.
- Unused state encodings (6, 7) → IDLE on the next clock.

## Timing
- Reset values: state IDLE, o_pipe_enable=0, o_fetch_enable=0, o_cycle_count=0, o_wb_count=0, o_done=0, o_state=0, drain_cnt=0, halt_seen=0.
- Reset has priority over all inputs in all states, including mid-DRAIN and mid-step.
- i_start_run high at edge n → o_pipe_enable=1 from cycle n+1.
- i_step sampled at edge n in STEP_WAIT → o_pipe_enable=1 for cycle n+1 only.
- i_step held high advances one cycle every 2 clocks, so the debug unit must pulse it.
- HALT fetched in enabled cycle k (RUN) → fetch_enable=0 from k+1, DRAIN covers k+1..k+DRAIN_CYCLES, o_done=1 from k+DRAIN_CYCLES+1.
- Total enabled cycles for a program = cycles up to and including the HALT fetch + DRAIN_CYCLES, identical in run and step modes.
- A counter increment and a state change in the same cycle both take effect. The counter uses the current-cycle o_pipe_enable.

## Structure
- Shared package: state encodings, state width (3), DRAIN_CYCLES default.
- Sub-module sat_counter (parameter LEN; ports i_clk, i_reset, i_clear, i_inc, o_count), instantiated twice: cycle counter and write-back counter.
- FSM and drain counter live in the top module.

## Test plan
- Reset: assert i_reset for 2 cycles with i_start_run=1 → all outputs 0, o_state=0 throughout; RUN entered one cycle after reset deasserts.
- Continuous run: i_start_run pulse; i_halt_fetched high in the 10th RUN cycle → o_fetch_enable falls after cycle 10, 4 DRAIN cycles follow, o_done=1, o_cycle_count=14.
- Single step: i_start_step, then 3 i_step pulses spaced 5 cycles → o_pipe_enable high exactly 3 single cycles, o_cycle_count=3, o_state returns to 2.
- Step with HALT: HALT on the 2nd step, then 4 more steps → DONE after the 6th step, o_cycle_count=6, o_fetch_enable=0 on steps 3–6, a 7th i_step is ignored.
- Write-back snooping in run mode: RegWrite=1 with write_reg=0 → no count; write_reg=5 → o_wb_count=1; RegWrite=1 in STEP_WAIT → no count.
- Reset mid-DRAIN, plus saturation: reset in the 2nd DRAIN cycle → IDLE and zeroed counters next cycle. Separately, with LEN=4, 20 RUN cycles → o_cycle_count=15, held.

Source files
------------

// File: rtl/pipeline_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl_pkg
//   Shared definitions for the MIPS pipeline execution controller:
//   FSM state encoding, state width and the default drain length.
// -----------------------------------------------------------------------------
package pipeline_run_ctrl_pkg;

    localparam int STATE_W              = 3;
    localparam int DRAIN_CYCLES_DEFAULT = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } run_state_e;

    // States in which the pipeline latches advance.
    function automatic logic pipe_active(input run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP_EXEC) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     i_clk    system clock
//     i_reset  synchronous active-high reset (count -> 0)
//     i_clear  synchronous clear (count -> 0), lower priority than reset
//     i_inc    increment enable
//     o_count  current count, LEN bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int LEN = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clear,
    input  logic           i_inc,
    output logic [LEN-1:0] o_count
);

    logic [LEN-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_inc && (count_q != '1)) begin
            count_q <= count_q + LEN'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl
//   Execution controller for the MIPS pipeline. Sequences the datapath in
//   continuous-run or single-step mode, stops fetching on HALT, drains the
//   pipeline until HALT retires and then reports done. Also counts enabled
//   cycles and committed (non-$0) register writes for the debug unit.
//   Ports:
//     i_clk, i_reset       clock, synchronous active-high reset
//     i_start_run          start continuous execution (IDLE only)
//     i_start_step         enter single-step mode (IDLE only)
//     i_step               advance one cycle (STEP_WAIT only)
//     i_halt_fetched       IF holds a HALT opcode
//     i_RegWrite,
//     i_write_reg          write-back stage register-write snoop
//     o_pipe_enable        global pipeline/latch enable
//     o_fetch_enable       PC update / IF enable
//     o_cycle_count        saturating count of enabled cycles
//     o_wb_count           saturating count of committed register writes
//     o_done               program finished
//     o_state              current FSM state
// -----------------------------------------------------------------------------
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int DRAIN_CYCLES         = DRAIN_CYCLES_DEFAULT  // must be >= 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start_run,
    input  logic                            i_start_step,
    input  logic                            i_step,
    input  logic                            i_halt_fetched,
    input  logic                            i_RegWrite,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    output logic                            o_pipe_enable,
    output logic                            o_fetch_enable,
    output logic [LEN-1:0]                  o_cycle_count,
    output logic [LEN-1:0]                  o_wb_count,
    output logic                            o_done,
    output logic [STATE_W-1:0]              o_state
);

    localparam int                 DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    run_state_e         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               halt_seen_q, halt_seen_d;
    logic               clear_cnt;
    logic               pipe_enable_q, fetch_enable_q, done_q;
    logic               wb_inc;

    // Next-state logic.
    // NOTE: every signal gets a default before the case statement so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        halt_seen_d = halt_seen_q;
        clear_cnt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start_run) begin
                    state_d     = ST_RUN;
                    clear_cnt   = 1'b1;
                    halt_seen_d = 1'b0;
                end else if (i_start_step) begin
                    state_d     = ST_STEP_WAIT;
                    clear_cnt   = 1'b1;
                    halt_seen_d = 1'b0;
                end
            end

            ST_RUN: begin
                if (i_halt_fetched) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end

            // drain_q counts the remaining enabled cycles including this one.
            ST_DRAIN: begin
                drain_d = drain_q - DRAIN_ONE;
                if (drain_q == DRAIN_ONE) begin
                    state_d = ST_DONE;
                end
            end

            ST_STEP_WAIT: begin
                if (i_step) begin
                    state_d = ST_STEP_EXEC;
                end
            end

            // Stepped equivalent of RUN/DRAIN: HALT detection and drain
            // countdown advance once per executed step.
            ST_STEP_EXEC: begin
                state_d = ST_STEP_WAIT;
                if (!halt_seen_q) begin
                    if (i_halt_fetched) begin
                        halt_seen_d = 1'b1;
                        drain_d     = DRAIN_LOAD;
                    end
                end else if (drain_q == DRAIN_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Outputs are decoded from the next state and registered
    // alongside it, so they line up with state_q without any input-to-output
    // combinational path.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            drain_q        <= '0;
            halt_seen_q    <= 1'b0;
            pipe_enable_q  <= 1'b0;
            fetch_enable_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            halt_seen_q    <= halt_seen_d;
            pipe_enable_q  <= pipe_active(state_d);
            fetch_enable_q <= (state_d == ST_RUN) ||
                              ((state_d == ST_STEP_EXEC) && !halt_seen_d);
            done_q         <= (state_d == ST_DONE);
        end
    end

    // Writes to $0 are architecturally discarded and never counted.
    assign wb_inc = pipe_enable_q && i_RegWrite && (i_write_reg != '0);

    sat_counter #(.LEN(LEN)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (clear_cnt),
        .i_inc   (pipe_enable_q),
        .o_count (o_cycle_count)
    );

    sat_counter #(.LEN(LEN)) u_wb_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (clear_cnt),
        .i_inc   (wb_inc),
        .o_count (o_wb_count)
    );

    assign o_pipe_enable  = pipe_enable_q;
    assign o_fetch_enable = fetch_enable_q;
    assign o_done         = done_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_ctrl
//   Scoreboard bench for pipeline_run_ctrl. Two instances share all inputs:
//   the default LEN=32 build and a LEN=4 build that exercises counter
//   saturation. The driver pushes the expected outputs of every cycle into a
//   queue; a monitor pops and compares on the falling edge.
//   The reference model works on program-level quantities: the operating mode,
//   the ordinal of the enabled cycle that fetched HALT, and the total number of
//   enabled cycles; the program is done once enabled cycles reach
//   halt ordinal + DRAIN.
// -----------------------------------------------------------------------------
module tb_pipeline_run_ctrl;

    localparam int LEN   = 32;
    localparam int LEN_S = 4;
    localparam int NB    = 5;
    localparam int DRAIN = 4;
    localparam longint SAT_S = 15;

    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_STEP = 2;
    localparam int MODE_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start_run, start_step, step, halt_fetched, reg_write;
    logic [NB-1:0] write_reg;

    logic            pipe_en, fetch_en, done;
    logic [LEN-1:0]  cyc, wb;
    logic [2:0]      state;
    logic            pipe_en_s, fetch_en_s, done_s;
    logic [LEN_S-1:0] cyc_s, wb_s;
    logic [2:0]      state_s;

    pipeline_run_ctrl #(.LEN(LEN), .NB_ADDRESS_REGISTROS(NB), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start_run    (start_run),
        .i_start_step   (start_step),
        .i_step         (step),
        .i_halt_fetched (halt_fetched),
        .i_RegWrite     (reg_write),
        .i_write_reg    (write_reg),
        .o_pipe_enable  (pipe_en),
        .o_fetch_enable (fetch_en),
        .o_cycle_count  (cyc),
        .o_wb_count     (wb),
        .o_done         (done),
        .o_state        (state)
    );

    pipeline_run_ctrl #(.LEN(LEN_S), .NB_ADDRESS_REGISTROS(NB), .DRAIN_CYCLES(DRAIN)) dut_small (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start_run    (start_run),
        .i_start_step   (start_step),
        .i_step         (step),
        .i_halt_fetched (halt_fetched),
        .i_RegWrite     (reg_write),
        .i_write_reg    (write_reg),
        .o_pipe_enable  (pipe_en_s),
        .o_fetch_enable (fetch_en_s),
        .o_cycle_count  (cyc_s),
        .o_wb_count     (wb_s),
        .o_done         (done_s),
        .o_state        (state_s)
    );

    typedef struct {
        logic       pipe;
        logic       fetch;
        logic       done;
        logic [2:0] state;
        longint     cyc;
        longint     wb;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // Reference model state
    int     m_mode    = MODE_IDLE;
    logic   m_en      = 1'b0;
    int     m_halt_at = -1;
    longint m_cyc     = 0;
    longint m_wb      = 0;

    // Apply inputs for the current cycle, predict the next cycle's outputs,
    // and queue the prediction once the clock edge has happened.
    task automatic drive(input logic rst, input logic sr, input logic ss, input logic st,
                         input logic hf, input logic rw, input logic [NB-1:0] wr);
        exp_t   e;
        logic   en_next;
        longint idx;
        reset = rst; start_run = sr; start_step = ss; step = st;
        halt_fetched = hf; reg_write = rw; write_reg = wr;

        en_next = 1'b0;
        if (rst) begin
            m_mode = MODE_IDLE; m_halt_at = -1; m_cyc = 0; m_wb = 0;
        end else begin
            if (m_en) begin
                m_cyc++;
                if (rw && wr != '0) m_wb++;
            end
            idx = m_cyc;
            case (m_mode)
                MODE_IDLE: begin
                    if (sr || ss) begin
                        m_mode    = sr ? MODE_RUN : MODE_STEP;
                        m_cyc     = 0;
                        m_wb      = 0;
                        m_halt_at = -1;
                        en_next   = sr;
                    end
                end
                MODE_RUN, MODE_STEP: begin
                    if (m_en) begin
                        if (m_halt_at < 0 && hf) m_halt_at = int'(idx);
                        if (m_halt_at >= 0 && idx == longint'(m_halt_at + DRAIN))
                            m_mode = MODE_DONE;
                        else
                            en_next = (m_mode == MODE_RUN);
                    end else begin
                        en_next = (m_mode == MODE_STEP) && st;
                    end
                end
                default: ;
            endcase
        end
        m_en = en_next;

        e.pipe  = en_next;
        e.fetch = en_next && (m_halt_at < 0);
        e.done  = (m_mode == MODE_DONE);
        case (m_mode)
            MODE_RUN:  e.state = (m_halt_at < 0) ? 3'd1 : 3'd4;
            MODE_STEP: e.state = en_next ? 3'd3 : 3'd2;
            MODE_DONE: e.state = 3'd5;
            default:   e.state = 3'd0;
        endcase
        e.cyc = m_cyc;
        e.wb  = m_wb;

        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Monitor: compares every queued expectation against both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pipe_enable",    longint'(pipe_en),    longint'(e.pipe));
                check("fetch_enable",   longint'(fetch_en),   longint'(e.fetch));
                check("done",           longint'(done),       longint'(e.done));
                check("state",          longint'(state),      longint'(e.state));
                check("cycle_count",    longint'(cyc),        e.cyc);
                check("wb_count",       longint'(wb),         e.wb);
                check("s_pipe_enable",  longint'(pipe_en_s),  longint'(e.pipe));
                check("s_fetch_enable", longint'(fetch_en_s), longint'(e.fetch));
                check("s_done",         longint'(done_s),     longint'(e.done));
                check("s_state",        longint'(state_s),    longint'(e.state));
                check("s_cycle_count",  longint'(cyc_s),      (e.cyc > SAT_S) ? SAT_S : e.cyc);
                check("s_wb_count",     longint'(wb_s),       (e.wb  > SAT_S) ? SAT_S : e.wb);
            end
        end
    end

    initial begin
        reset = 1'b1; start_run = 1'b0; start_step = 1'b0; step = 1'b0;
        halt_fetched = 1'b0; reg_write = 1'b0; write_reg = '0;

        // Reset held two cycles with start_run high, then released.
        drive(1, 1, 0, 0, 0, 0, '0);
        drive(1, 1, 0, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, '0);
        check("run_entered_after_reset", longint'(state), 1);

        // Continuous run: HALT in the 10th RUN cycle.
        for (int i = 1; i <= 10; i++) drive(0, 0, 0, 0, (i == 10), 0, '0);
        check("halt_cycle_fetch_off", longint'(fetch_en), 0);
        idle_cycles(6);
        check("run_cycle_count", longint'(cyc), 14);
        check("run_done", longint'(done), 1);

        // Write-back snooping in run mode.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 1, 5'd0);
        drive(0, 0, 0, 0, 0, 1, 5'd5);
        drive(0, 0, 0, 0, 1, 0, '0);
        idle_cycles(6);
        check("wb_run_count", longint'(wb), 1);

        // Single step: three pulses spaced five cycles; RegWrite in STEP_WAIT.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 1, 0, 0, 0, '0);
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, 0, 1, 0, 1, 5'd9);
            idle_cycles(4);
        end
        check("step_cycle_count", longint'(cyc), 3);
        check("step_wait_wb_count", longint'(wb), 0);
        check("step_state_wait", longint'(state), 2);

        // Step with HALT on the 2nd step; 7th step must be ignored.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 1, 0, 0, 0, '0);
        for (int s = 1; s <= 7; s++) begin
            drive(0, 0, 0, 1, 0, 0, '0);
            drive(0, 0, 0, 0, (s == 2), 0, '0);
            idle_cycles(2);
        end
        check("step_halt_cycle_count", longint'(cyc), 6);
        check("step_halt_done", longint'(done), 1);

        // i_step held high: one step every two clocks.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 0, '0);
        check("step_held_cycle_count", longint'(cyc), 4);

        // Reset in the 2nd DRAIN cycle.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 0, '0);
        drive(0, 0, 0, 0, 0, 0, '0);
        drive(1, 1, 0, 0, 0, 0, '0);
        check("mid_drain_reset_state", longint'(state), 0);
        check("mid_drain_reset_count", longint'(cyc), 0);

        // Saturation of the LEN=4 instance: 20 RUN cycles, then more.
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 1, 5'd3);
        check("sat_small_count", longint'(cyc_s), 15);
        check("sat_big_count", longint'(cyc), 20);
        drive(0, 0, 0, 0, 1, 0, '0);
        idle_cycles(6);
        check("sat_small_held", longint'(cyc_s), 15);

        // Randomized episodes.
        for (int ep = 0; ep < 12; ep++) begin
            drive(1, 0, 0, 0, 0, 0, '0);
            for (int i = 0; i < 80; i++) begin
                drive(($urandom % 100) == 0,
                      ($urandom % 8) == 0,
                      ($urandom % 8) == 1,
                      ($urandom % 3) == 0,
                      ($urandom % 10) == 0,
                      1'($urandom % 2),
                      NB'($urandom_range(0, 3)));
            end
        end

        idle_cycles(2);
        @(negedge clk);
        #1;
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
